mem_dma: RTL and testbench

- Sequential bulk-transfer initiator for the 256x16 main memory.
- Drives the master end of one mem_rwport.
- Load command: consumes a valid/ready word stream (front panel / host loader) and writes it to consecutive addresses.
- Dump command: reads consecutive addresses and emits them on a valid/ready output stream.

---
 rtl/mem_dma.sv | 153 +++++++++++++++
 tb/tb_mem_dma.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_dma.sv
// mem_dma: sequential bulk-transfer initiator for a 2**AW x DW memory.
//   Load: writes a valid/ready input word stream to consecutive addresses.
//   Dump: reads consecutive addresses and emits them on a valid/ready stream.
// Ports:
//   clk_i, rst_ni            clock; synchronous active-high reset
//   cmd_*                    command handshake (dump/load, base address, count-1)
//   in_val_i/in_rdy_o/in_data_i      load data stream (sink)
//   out_val_o/out_rdy_i/out_data_o   dump data stream (source)
//   busy_o, done_o           status: command in progress / completion pulse
//   mem_*                    master side of the memory read/write port
module mem_dma #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 16
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          cmd_val_i,
    output logic          cmd_rdy_o,
    input  logic          cmd_dump_i,
    input  logic [AW-1:0] cmd_base_i,
    input  logic [AW-1:0] cmd_cnt_i,
    input  logic          in_val_i,
    output logic          in_rdy_o,
    input  logic [DW-1:0] in_data_i,
    output logic          out_val_o,
    input  logic          out_rdy_i,
    output logic [DW-1:0] out_data_o,
    output logic          busy_o,
    output logic          done_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    output logic          mem_wen_o,
    output logic          mem_val_o,
    input  logic [DW-1:0] mem_rdata_i,
    input  logic          mem_rdy_i
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_RD_REQ  = 3'd2,
        S_RD_WAIT = 3'd3,
        S_OUT     = 3'd4,
        S_DONE    = 3'd5
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] buf_q, buf_d;

    // State and datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        buf_d       = buf_q;
        cmd_rdy_o   = 1'b0;
        in_rdy_o    = 1'b0;
        out_val_o   = 1'b0;
        out_data_o  = buf_q;
        busy_o      = (state_q != S_IDLE);
        done_o      = 1'b0;
        mem_addr_o  = ptr_q;
        mem_wdata_o = '0;
        mem_wen_o   = 1'b0;
        mem_val_o   = 1'b0;

        case (state_q)
            S_IDLE: begin
                cmd_rdy_o = 1'b1;
                if (cmd_val_i) begin
                    ptr_d   = cmd_base_i;
                    cnt_d   = cmd_cnt_i;
                    state_d = cmd_dump_i ? S_RD_REQ : S_LOAD;
                end
            end
            S_LOAD: begin
                // Input is only ready when the memory can take the write this cycle
                in_rdy_o = mem_rdy_i;
                if (in_val_i && mem_rdy_i) begin
                    mem_val_o   = 1'b1;
                    mem_wen_o   = 1'b1;
                    mem_wdata_o = in_data_i;
                    ptr_d       = AW'(ptr_q + 1'b1);
                    if (cnt_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d = AW'(cnt_q - 1'b1);
                    end
                end
            end
            S_RD_REQ: begin
                if (mem_rdy_i) begin
                    mem_val_o = 1'b1;
                    state_d   = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                // Registered read data arrives one cycle after the request
                buf_d   = mem_rdata_i;
                state_d = S_OUT;
            end
            S_OUT: begin
                out_val_o = 1'b1;
                if (out_rdy_i) begin
                    ptr_d = AW'(ptr_q + 1'b1);
                    if (cnt_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = AW'(cnt_q - 1'b1);
                        state_d = S_RD_REQ;
                    end
                end
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Reset cycle: suppress all handshakes and memory traffic immediately
        if (rst_ni) begin
            cmd_rdy_o   = 1'b0;
            in_rdy_o    = 1'b0;
            out_val_o   = 1'b0;
            busy_o      = 1'b0;
            done_o      = 1'b0;
            mem_val_o   = 1'b0;
            mem_wen_o   = 1'b0;
            mem_wdata_o = '0;
        end
    end

endmodule

// File: tb/tb_mem_dma.sv
// Directed self-checking bench for mem_dma with a 256x16 registered-read memory model.
module tb_mem_dma;
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 16;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          cmd_val_i;
    logic          cmd_rdy_o;
    logic          cmd_dump_i;
    logic [AW-1:0] cmd_base_i;
    logic [AW-1:0] cmd_cnt_i;
    logic          in_val_i;
    logic          in_rdy_o;
    logic [DW-1:0] in_data_i;
    logic          out_val_o;
    logic          out_rdy_i;
    logic [DW-1:0] out_data_o;
    logic          busy_o;
    logic          done_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic          mem_wen_o;
    logic          mem_val_o;
    logic [DW-1:0] mem_rdata_i;
    logic          mem_rdy_i;

    always #5 clk_i = ~clk_i;

    mem_dma #(.AW(AW), .DW(DW)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .cmd_val_i   (cmd_val_i),
        .cmd_rdy_o   (cmd_rdy_o),
        .cmd_dump_i  (cmd_dump_i),
        .cmd_base_i  (cmd_base_i),
        .cmd_cnt_i   (cmd_cnt_i),
        .in_val_i    (in_val_i),
        .in_rdy_o    (in_rdy_o),
        .in_data_i   (in_data_i),
        .out_val_o   (out_val_o),
        .out_rdy_i   (out_rdy_i),
        .out_data_o  (out_data_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_wen_o   (mem_wen_o),
        .mem_val_o   (mem_val_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_rdy_i   (mem_rdy_i)
    );

    // Memory model: writes and registered reads on accepted accesses
    logic [DW-1:0] mem [0:255];
    logic          fill_mem;
    int            wr_cnt   = 0;
    int            rd_cnt   = 0;
    int            done_cnt = 0;

    always @(posedge clk_i) begin
        if (fill_mem) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'hDE00 | 16'(i);
            mem_rdata_i <= '0;
        end else begin
            if (done_o) done_cnt++;
            if (mem_val_o && mem_rdy_i) begin
                if (mem_wen_o) begin
                    mem[mem_addr_o] <= mem_wdata_o;
                    wr_cnt++;
                end else begin
                    mem_rdata_i <= mem[mem_addr_o];
                    rd_cnt++;
                end
            end
        end
    end

    int checks   = 0;
    int failures = 0;
    logic [DW-1:0] vec [0:7];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic start_cmd(input logic dump, input logic [AW-1:0] base, input logic [AW-1:0] cnt);
        cmd_val_i  = 1'b1;
        cmd_dump_i = dump;
        cmd_base_i = base;
        cmd_cnt_i  = cnt;
        #1;
        check_eq("cmd_rdy_idle", 32'(cmd_rdy_o), 1);
        step();
        cmd_val_i = 1'b0;
    endtask

    task automatic run_load(input logic [AW-1:0] base, input int cnt);
        int w0;
        int d0;
        logic [AW-1:0] a;
        w0 = wr_cnt;
        d0 = done_cnt;
        for (int i = 0; i <= cnt; i++) begin
            a = 8'(int'(base) + i);
            in_val_i  = 1'b1;
            in_data_i = vec[i];
            #1;
            check_eq("load_in_rdy", 32'(in_rdy_o), 1);
            check_eq("load_val_wen", {30'd0, mem_val_o, mem_wen_o}, 3);
            check_eq("load_addr", 32'(mem_addr_o), 32'(a));
            check_eq("load_wdata", 32'(mem_wdata_o), 32'(vec[i]));
            step();
        end
        in_val_i = 1'b0;
        #1;
        check_eq("load_done", 32'(done_o), 1);
        check_eq("load_done_memval", 32'(mem_val_o), 0);
        step();
        check_eq("load_idle_busy", 32'(busy_o), 0);
        check_eq("load_idle_done", 32'(done_o), 0);
        check_eq("load_idle_cmdrdy", 32'(cmd_rdy_o), 1);
        check_eq("load_wr_count", 32'(wr_cnt - w0), 32'(cnt + 1));
        check_eq("load_done_count", 32'(done_cnt - d0), 1);
        for (int i = 0; i <= cnt; i++) begin
            a = 8'(int'(base) + i);
            check_eq("load_mem", 32'(mem[a]), 32'(vec[i]));
        end
    endtask

    task automatic run_dump(input logic [AW-1:0] base, input int cnt, input int stall, input int rdy_hold);
        int r0;
        int d0;
        logic [AW-1:0] a;
        d0 = done_cnt;
        for (int i = 0; i <= cnt; i++) begin
            a = 8'(int'(base) + i);
            if (i == 0) begin
                for (int k = 0; k < rdy_hold; k++) begin
                    mem_rdy_i = 1'b0;
                    #1;
                    check_eq("rdreq_hold_val", 32'(mem_val_o), 0);
                    check_eq("rdreq_hold_busy", 32'(busy_o), 1);
                    step();
                end
                mem_rdy_i = 1'b1;
            end
            out_rdy_i = 1'b0;
            #1;
            check_eq("rdreq_val_wen", {30'd0, mem_val_o, mem_wen_o}, 2);
            check_eq("rdreq_addr", 32'(mem_addr_o), 32'(a));
            check_eq("rdreq_outval", 32'(out_val_o), 0);
            r0 = rd_cnt;
            step();
            check_eq("rd_count", 32'(rd_cnt - r0), 1);
            check_eq("rdwait_val", 32'(mem_val_o), 0);
            check_eq("rdwait_outval", 32'(out_val_o), 0);
            step();
            if (i == 0) begin
                for (int k = 0; k < stall; k++) begin
                    out_rdy_i = 1'b0;
                    #1;
                    check_eq("stall_outval", 32'(out_val_o), 1);
                    check_eq("stall_data", 32'(out_data_o), 32'(vec[i]));
                    check_eq("stall_memval", 32'(mem_val_o), 0);
                    step();
                end
                check_eq("stall_no_read", 32'(rd_cnt - r0), 1);
            end
            out_rdy_i = 1'b1;
            #1;
            check_eq("out_val", 32'(out_val_o), 1);
            check_eq("out_data", 32'(out_data_o), 32'(vec[i]));
            check_eq("out_memval", 32'(mem_val_o), 0);
            step();
            out_rdy_i = 1'b0;
        end
        #1;
        check_eq("dump_done", 32'(done_o), 1);
        check_eq("dump_done_outval", 32'(out_val_o), 0);
        step();
        check_eq("dump_idle_busy", 32'(busy_o), 0);
        check_eq("dump_idle_done", 32'(done_o), 0);
        check_eq("dump_done_count", 32'(done_cnt - d0), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int w0;
        int d0;
        rst_ni     = 1'b1;
        fill_mem   = 1'b1;
        cmd_val_i  = 1'b0;
        cmd_dump_i = 1'b0;
        cmd_base_i = '0;
        cmd_cnt_i  = '0;
        in_val_i   = 1'b0;
        in_data_i  = '0;
        out_rdy_i  = 1'b0;
        mem_rdy_i  = 1'b1;
        #1;
        check_eq("rst_cmd_rdy", 32'(cmd_rdy_o), 0);
        check_eq("rst_busy", 32'(busy_o), 0);
        step();
        rst_ni   = 1'b0;
        fill_mem = 1'b0;
        #1;
        check_eq("post_rst_cmd_rdy", 32'(cmd_rdy_o), 1);
        check_eq("post_rst_status", {28'd0, busy_o, done_o, in_rdy_o, out_val_o}, 0);
        check_eq("post_rst_mem", {30'd0, mem_val_o, mem_wen_o}, 0);
        check_eq("post_rst_outdata", 32'(out_data_o), 0);

        // 1/2: load then dump three words at 0x10
        vec[0] = 16'hA001; vec[1] = 16'hA002; vec[2] = 16'hA003;
        start_cmd(1'b0, 8'h10, 8'd2);
        run_load(8'h10, 2);
        start_cmd(1'b1, 8'h10, 8'd2);
        run_dump(8'h10, 2, 0, 0);

        // 3: address wrap 0xFE..0x01
        vec[0] = 16'd1; vec[1] = 16'd2; vec[2] = 16'd3; vec[3] = 16'd4;
        start_cmd(1'b0, 8'hFE, 8'd3);
        run_load(8'hFE, 3);
        start_cmd(1'b1, 8'hFE, 8'd3);
        run_dump(8'hFE, 3, 0, 0);

        // 4: backpressure on first word, memory not ready on first request
        vec[0] = 16'hA001; vec[1] = 16'hA002;
        start_cmd(1'b1, 8'h10, 8'd1);
        run_dump(8'h10, 1, 5, 2);

        // 5: stream gaps and a command pulse while busy
        w0 = wr_cnt;
        start_cmd(1'b0, 8'h40, 8'd1);
        in_val_i = 1'b1; in_data_i = 16'hB001;
        #1;
        check_eq("gap_w0_addr", 32'(mem_addr_o), 32'h40);
        check_eq("gap_w0_val", 32'(mem_val_o), 1);
        step();
        in_val_i = 1'b0;
        cmd_val_i = 1'b1; cmd_dump_i = 1'b1; cmd_base_i = 8'h80; cmd_cnt_i = 8'd0;
        #1;
        check_eq("busy_cmd_rdy", 32'(cmd_rdy_o), 0);
        check_eq("gap_memval1", 32'(mem_val_o), 0);
        step();
        cmd_val_i = 1'b0;
        #1;
        check_eq("gap_memval2", 32'(mem_val_o), 0);
        check_eq("gap_busy", 32'(busy_o), 1);
        step();
        in_val_i = 1'b1; in_data_i = 16'hB002; mem_rdy_i = 1'b0;
        #1;
        check_eq("memrdy_low_in_rdy", 32'(in_rdy_o), 0);
        check_eq("memrdy_low_val", 32'(mem_val_o), 0);
        step();
        mem_rdy_i = 1'b1;
        #1;
        check_eq("gap_w1_addr", 32'(mem_addr_o), 32'h41);
        check_eq("gap_w1_wdata", 32'(mem_wdata_o), 32'hB002);
        step();
        in_val_i = 1'b0;
        #1;
        check_eq("gap_done", 32'(done_o), 1);
        step();
        check_eq("gap_idle_busy", 32'(busy_o), 0);
        check_eq("gap_wr_count", 32'(wr_cnt - w0), 2);
        check_eq("gap_mem40", 32'(mem[8'h40]), 32'hB001);
        check_eq("gap_mem41", 32'(mem[8'h41]), 32'hB002);
        check_eq("gap_mem42", 32'(mem[8'h42]), 32'hDE42);
        step();
        check_eq("gap_no_dump", 32'(busy_o), 0);

        // 6: reset after two of four load words
        w0 = wr_cnt;
        d0 = done_cnt;
        start_cmd(1'b0, 8'h60, 8'd3);
        in_val_i = 1'b1; in_data_i = 16'hC001;
        step();
        in_data_i = 16'hC002;
        step();
        in_data_i = 16'hC003;
        rst_ni = 1'b1;
        #1;
        check_eq("midrst_memval", 32'(mem_val_o), 0);
        check_eq("midrst_cmd_rdy", 32'(cmd_rdy_o), 0);
        step();
        rst_ni = 1'b0;
        #1;
        check_eq("after_rst_busy", 32'(busy_o), 0);
        check_eq("after_rst_done", 32'(done_o), 0);
        check_eq("after_rst_in_rdy", 32'(in_rdy_o), 0);
        check_eq("after_rst_memval", 32'(mem_val_o), 0);
        check_eq("after_rst_cmd_rdy", 32'(cmd_rdy_o), 1);
        in_val_i = 1'b0;
        step();
        check_eq("rst_done_count", 32'(done_cnt - d0), 0);
        check_eq("rst_wr_count", 32'(wr_cnt - w0), 2);
        check_eq("rst_mem60", 32'(mem[8'h60]), 32'hC001);
        check_eq("rst_mem61", 32'(mem[8'h61]), 32'hC002);
        check_eq("rst_mem62", 32'(mem[8'h62]), 32'hDE62);
        check_eq("rst_mem63", 32'(mem[8'h63]), 32'hDE63);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
